cmp_search_seq: RTL and testbench

Sequencer that drives the B side of an external 8-bit identity comparator, modelled by the 74x521 pin model, and scans candidate values until the comparator reports equality. It sits between control logic and a comparator whose A side is set by the unknown, e.g. a latched bus value or a DIP-switch address. It returns the matching value, or a not-found flag.

---
 rtl/cmp_search_pkg.sv | 16 +
 rtl/cmp_search_seq.sv | 103 ++++++++++
 tb/tb_cmp_search_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cmp_search_pkg.sv
// Shared definitions for the comparator-driven search sequencer:
// FSM state encoding and design-wide constants.
`timescale 1ns/1ps
package cmp_search_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int SETTLE_MAX    = 15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/cmp_search_seq.sv
// Scans probe values 0..2^WIDTH-1 into an external 74x521 identity comparator
// until it reports equality; returns the matching value or a not-found flag.
`timescale 1ns/1ps
module cmp_search_seq
  import cmp_search_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_n,
  output logic [WIDTH-1:0] probe,
  output logic             en_n,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result
);

  localparam logic [3:0]       RELOAD = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST   = '1;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last;
  logic       active_nxt;

  assign last       = (probe == LAST);
  assign active_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)           state_nxt = S_DONE;
        else if (cnt == '0)  state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort || !cmp_n || last) state_nxt = S_DONE;
        else                         state_nxt = S_SETTLE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      probe  <= '0;
      en_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      // Outputs follow the next state so they change on the same edge as the FSM.
      en_n  <= !active_nxt;
      busy  <= active_nxt;
      done  <= (state_nxt == S_DONE);

      unique case (state)
        S_IDLE: begin
          if (start) begin
            probe <= '0;
            cnt   <= RELOAD;
            found <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort)           found <= 1'b0;
          else if (cnt != '0)  cnt   <= cnt - 4'd1;
        end
        S_SAMPLE: begin
          // Abort wins over a match seen in the same cycle.
          if (abort) begin
            found <= 1'b0;
          end else if (!cmp_n) begin
            result <= probe;
            found  <= 1'b1;
          end else if (last) begin
            found  <= 1'b0;
            result <= '0;
          end else begin
            probe <= probe + WIDTH'(1);
            cnt   <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search_seq.sv
// Self-checking bench: two sequencers (SETTLE=1 and SETTLE=3) each driving a
// behavioural 74x521 model; expected done cycle/result come from a closed-form model.
`timescale 1ns/1ps
module tb_cmp_search_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       abort = 1'b0;
  logic       force_ne = 1'b0;
  logic [7:0] target = 8'h00;

  logic       cmp_n1, cmp_n3;
  logic [7:0] probe1, probe3, result1, result3;
  logic       en_n1, en_n3, busy1, busy3, done1, done3, found1, found3;

  int checks = 0;
  int failures = 0;
  int sel = 1;

  logic [7:0] m_probe, m_result;
  logic       m_en_n, m_busy, m_done, m_found;

  always #5 clk = ~clk;

  // 74x521 pin model: port19 (P=Q, active low) is low only when port1 (G, active low) is low and A == B.
  assign cmp_n1 = force_ne | ~(~en_n1 & (probe1 == target));
  assign cmp_n3 = force_ne | ~(~en_n3 & (probe3 == target));

  cmp_search_seq #(.WIDTH(8), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .cmp_n(cmp_n1),
    .probe(probe1), .en_n(en_n1), .busy(busy1), .done(done1),
    .found(found1), .result(result1)
  );

  cmp_search_seq #(.WIDTH(8), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .cmp_n(cmp_n3),
    .probe(probe3), .en_n(en_n3), .busy(busy3), .done(done3),
    .found(found3), .result(result3)
  );

  always_comb begin
    if (sel == 3) begin
      m_probe = probe3; m_result = result3; m_en_n = en_n3;
      m_busy  = busy3;  m_done   = done3;   m_found = found3;
    end else begin
      m_probe = probe1; m_result = result1; m_en_n = en_n1;
      m_busy  = busy1;  m_done   = done1;   m_found = found1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " probe"},  32'(m_probe),  32'h0);
    check({tag, " en_n"},   32'(m_en_n),   32'h1);
    check({tag, " busy"},   32'(m_busy),   32'h0);
    check({tag, " done"},   32'(m_done),   32'h0);
    check({tag, " found"},  32'(m_found),  32'h0);
    check({tag, " result"}, 32'(m_result), 32'h0);
  endtask

  // One scan. Cycle c is observed at the falling edge following start edge + (c-1).
  task automatic scan(input string tag, input int s, input logic [7:0] a, input bit no_match,
                      input int abort_at, input int rst_at, input int extra_start_at);
    int         natural_cyc, exp_cyc, done_cyc, pulses, limit;
    logic       exp_found, d_found, d_busy, d_en_n;
    logic [7:0] exp_res, d_res;

    sel = s; target = a; force_ne = no_match;
    // Candidate k costs s+1 cycles; done appears 2 + s cycles after its slot opens.
    natural_cyc = no_match ? 2 + (s + 1) * 255 + s : 2 + (s + 1) * int'(a) + s;
    exp_found   = !no_match;
    exp_res     = no_match ? 8'h00 : a;
    exp_cyc     = natural_cyc;
    if (abort_at > 0 && abort_at < natural_cyc) begin
      exp_cyc   = abort_at + 1;
      exp_found = 1'b0;
    end
    limit    = (rst_at > 0) ? rst_at + 6 : exp_cyc + 4;
    done_cyc = -1; pulses = 0;
    d_found = 1'bx; d_busy = 1'bx; d_en_n = 1'bx; d_res = 'x;

    @(negedge clk);
    if (s == 3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (cyc > 1) @(negedge clk);
      abort = (cyc == abort_at);
      rst   = (cyc == rst_at);
      if (s == 3) start3 = (cyc == extra_start_at);
      else        start1 = (cyc == extra_start_at);
      if (cyc == 1) begin
        check({tag, " busy at cycle 1"}, 32'(m_busy), 32'h1);
        check({tag, " en_n at cycle 1"}, 32'(m_en_n), 32'h0);
      end
      if (m_done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          d_found = m_found; d_res = m_result; d_busy = m_busy; d_en_n = m_en_n;
        end
      end
      if (rst_at > 0 && cyc == rst_at + 1) check_reset_values({tag, " after rst"});
    end
    abort = 1'b0; rst = 1'b0; start1 = 1'b0; start3 = 1'b0;

    if (rst_at > 0) begin
      check({tag, " done pulses"}, 32'(pulses), 32'h0);
    end else begin
      check({tag, " done cycle"},   32'(done_cyc), 32'(exp_cyc));
      check({tag, " done pulses"},  32'(pulses),   32'h1);
      check({tag, " found"},        32'(d_found),  32'(exp_found));
      if (abort_at == 0) check({tag, " result"}, 32'(d_res), 32'(exp_res));
      check({tag, " busy at done"}, 32'(d_busy),   32'h0);
      check({tag, " en_n at done"}, 32'(d_en_n),   32'h1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sel = 1; #0 check_reset_values("reset u1");
    sel = 3; #0 check_reset_values("reset u3");
    rst = 1'b0;
    @(negedge clk);

    scan("s1 a=00",      1, 8'h00, 1'b0, 0,  0, 0);
    scan("s1 a=5a",      1, 8'h5A, 1'b0, 0,  0, 0);
    scan("s1 a=ff",      1, 8'hFF, 1'b0, 0,  0, 0);
    scan("s1 nomatch",   1, 8'h33, 1'b1, 0,  0, 0);
    scan("s3 a=10",      3, 8'h10, 1'b0, 0,  0, 10);
    scan("s1 abort@40",  1, 8'h5A, 1'b0, 40, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int s_r;
      logic [7:0] a_r;
      s_r = ($urandom_range(0, 1) == 0) ? 1 : 3;
      a_r = 8'($urandom_range(0, 255));
      scan($sformatf("rand%0d s%0d a=%02h", i, s_r, a_r), s_r, a_r, 1'b0, 0, 0, 0);
    end
    scan("s1 rst@40",    1, 8'h80, 1'b0, 0, 40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
